// File: rtl/round_ctrl.sv
// Round controller for a target-shooting game: sequences rounds, times out the
// aim window, judges shots against the current target and keeps the score.
module round_ctrl #(
    parameter int unsigned NUM_ROUNDS     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned TOL_X          = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       btn_start,
    input  logic       shot_valid,
    input  logic [4:0] shot_x,
    input  logic [4:0] shot_y,
    input  logic [4:0] target_x,
    input  logic [4:0] target_y,
    output logic       start_new_game,
    output logic       result_valid,
    output logic       hit,
    output logic [7:0] score,
    output logic [3:0] rounds_left,
    output logic       game_over
);

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned SCORE_W = 8;
    localparam int unsigned ROUND_W = 4;
    localparam int unsigned DIST_W  = 6;

    localparam logic [CNT_W-1:0]   TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DIST_W-1:0]  TOL        = DIST_W'(TOL_X);
    localparam logic [ROUND_W-1:0] ROUNDS     = ROUND_W'(NUM_ROUNDS);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_AIM    = 3'd3,
        S_JUDGE  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_tmo;
    logic                 r_hit;
    logic [SCORE_W-1:0]   r_score;
    logic [ROUND_W-1:0]   r_rounds;

    logic [DIST_W-1:0]    w_dx;
    logic                 w_shot_hit;
    logic                 w_judge_hit;
    logic                 w_timeout;
    logic [ROUND_W-1:0]   w_rounds_dec;

    // Hit rule: absolute X distance widened so 31 vs 0 stays 31, never wraps.
    always_comb begin
        w_dx         = '0;
        w_shot_hit   = 1'b0;
        w_judge_hit  = 1'b0;
        w_timeout    = 1'b0;
        w_rounds_dec = '0;

        if (shot_x >= target_x) begin
            w_dx = DIST_W'(shot_x) - DIST_W'(target_x);
        end else begin
            w_dx = DIST_W'(target_x) - DIST_W'(shot_x);
        end

        w_shot_hit   = (shot_y == target_y) && (w_dx <= TOL);
        w_judge_hit  = shot_valid && w_shot_hit;
        w_timeout    = (r_tmo == TMO_LAST);
        w_rounds_dec = (r_rounds == '0) ? '0 : r_rounds - ROUND_W'(1);
    end

    // Game sequencer; every register holds while ena is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_tmo    <= '0;
            r_hit    <= 1'b0;
            r_score  <= '0;
            r_rounds <= '0;
        end else if (ena) begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (btn_start) begin
                        r_state  <= S_LOAD;
                        r_score  <= '0;
                        r_rounds <= ROUNDS;
                        r_hit    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    r_state <= S_AIM;
                    r_tmo   <= '0;
                end
                S_AIM: begin
                    // A shot in the final timeout cycle is still judged as a shot.
                    if (shot_valid || w_timeout) begin
                        r_state  <= S_JUDGE;
                        r_hit    <= w_judge_hit;
                        r_rounds <= w_rounds_dec;
                        if (w_judge_hit && (r_score != SCORE_MAX)) begin
                            r_score <= r_score + SCORE_W'(1);
                        end
                    end else begin
                        r_tmo <= r_tmo + CNT_W'(1);
                    end
                end
                S_JUDGE: begin
                    if (r_rounds == '0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_LOAD;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Pulses are qualified by ena so a stalled pulse state emits exactly once.
    assign start_new_game = (r_state == S_LOAD)  && ena && !reset;
    assign result_valid   = (r_state == S_JUDGE) && ena && !reset;
    assign game_over      = (r_state == S_DONE);
    assign hit            = r_hit;
    assign score          = r_score;
    assign rounds_left    = r_rounds;

endmodule

// File: tb/tb_round_ctrl.sv
// Self-checking bench for round_ctrl: two configurations share one stimulus
// stream and are checked by directed scenarios and a randomized model run.
module tb_round_ctrl;

    localparam int A_NR  = 8;
    localparam int A_TMO = 20;
    localparam int A_TOL = 1;
    localparam int B_NR  = 2;
    localparam int B_TMO = 4;
    localparam int B_TOL = 0;

    localparam int P_IDLE   = 0;
    localparam int P_LOAD   = 1;
    localparam int P_SETTLE = 2;
    localparam int P_AIM    = 3;
    localparam int P_JUDGE  = 4;
    localparam int P_DONE   = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       ena;
    logic       btn_start;
    logic       shot_valid;
    logic [4:0] shot_x;
    logic [4:0] shot_y;
    logic [4:0] target_x;
    logic [4:0] target_y;

    logic       snp [2];
    logic       rv  [2];
    logic       hv  [2];
    logic       go  [2];
    logic [7:0] sc  [2];
    logic [3:0] rl  [2];

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state per instance (0 = config A, 1 = config B)
    int m_ph    [2];
    int m_age   [2];
    int m_score [2];
    int m_rnd   [2];
    bit m_hit   [2];

    always #5 clk = ~clk;

    round_ctrl #(.NUM_ROUNDS(A_NR), .TIMEOUT_CYCLES(A_TMO), .TOL_X(A_TOL)) dut_a (
        .clk(clk), .reset(reset), .ena(ena), .btn_start(btn_start),
        .shot_valid(shot_valid), .shot_x(shot_x), .shot_y(shot_y),
        .target_x(target_x), .target_y(target_y),
        .start_new_game(snp[0]), .result_valid(rv[0]), .hit(hv[0]),
        .score(sc[0]), .rounds_left(rl[0]), .game_over(go[0])
    );

    round_ctrl #(.NUM_ROUNDS(B_NR), .TIMEOUT_CYCLES(B_TMO), .TOL_X(B_TOL)) dut_b (
        .clk(clk), .reset(reset), .ena(ena), .btn_start(btn_start),
        .shot_valid(shot_valid), .shot_x(shot_x), .shot_y(shot_y),
        .target_x(target_x), .target_y(target_y),
        .start_new_game(snp[1]), .result_valid(rv[1]), .hit(hv[1]),
        .score(sc[1]), .rounds_left(rl[1]), .game_over(go[1])
    );

    function automatic int cfg_nr(int i);
        return (i == 0) ? A_NR : B_NR;
    endfunction

    function automatic int cfg_tmo(int i);
        return (i == 0) ? A_TMO : B_TMO;
    endfunction

    function automatic int cfg_tol(int i);
        return (i == 0) ? A_TOL : B_TOL;
    endfunction

    function automatic bit hit_rule(int sx, int sy, int tx, int ty, int tol);
        int d;
        d = sx - tx;
        if (d < 0) d = -d;
        return (sy == ty) && (d <= tol);
    endfunction

    function automatic bit exp_snp(int i);
        return (m_ph[i] == P_LOAD) && (ena === 1'b1) && (reset === 1'b0);
    endfunction

    function automatic bit exp_rv(int i);
        return (m_ph[i] == P_JUDGE) && (ena === 1'b1) && (reset === 1'b0);
    endfunction

    // Advance the game model by one clock using the inputs about to be sampled.
    task automatic model_step();
        bit h;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_ph[i] = P_IDLE; m_age[i] = 0; m_score[i] = 0; m_rnd[i] = 0; m_hit[i] = 1'b0;
            end else if (ena) begin
                case (m_ph[i])
                    P_IDLE, P_DONE: begin
                        if (btn_start) begin
                            m_ph[i] = P_LOAD; m_score[i] = 0; m_rnd[i] = cfg_nr(i); m_hit[i] = 1'b0;
                        end
                    end
                    P_LOAD:   m_ph[i] = P_SETTLE;
                    P_SETTLE: begin m_ph[i] = P_AIM; m_age[i] = 0; end
                    P_AIM: begin
                        if (shot_valid || (m_age[i] + 1 == cfg_tmo(i))) begin
                            h = shot_valid && hit_rule(int'(shot_x), int'(shot_y), int'(target_x), int'(target_y), cfg_tol(i));
                            m_ph[i] = P_JUDGE;
                            m_hit[i] = h;
                            if (h) m_score[i] = (m_score[i] >= 255) ? 255 : m_score[i] + 1;
                            m_rnd[i] = (m_rnd[i] > 0) ? m_rnd[i] - 1 : 0;
                        end else begin
                            m_age[i] = m_age[i] + 1;
                        end
                    end
                    P_JUDGE: m_ph[i] = (m_rnd[i] == 0) ? P_DONE : P_LOAD;
                    default: m_ph[i] = P_IDLE;
                endcase
            end
        end
    endtask

    task automatic nxt();
        model_step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_aim(input int inst);
        int k;
        k = 0;
        shot_valid = 1'b0;
        while (m_ph[inst] != P_AIM && k < 60) begin
            nxt();
            k++;
        end
        if (m_ph[inst] != P_AIM) begin
            n_chk++; n_fail++;
            $display("FAIL wait_aim: instance %0d never reached aim window, phase %0d", inst, m_ph[inst]);
        end
    endtask

    task automatic shoot(input int inst, input int sx, input int sy, input int tx, input int ty);
        wait_aim(inst);
        target_x = 5'(tx); target_y = 5'(ty);
        shot_x = 5'(sx); shot_y = 5'(sy);
        shot_valid = 1'b1;
        nxt();
        shot_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; ena = 1'b0; btn_start = 1'b1; shot_valid = 1'b1;
        nxt(); nxt();
        #1;
        for (int i = 0; i < 2; i++) begin
            n_chk++; if (snp[i] !== 1'b0) begin n_fail++; $display("FAIL reset_snp[%0d]: got %b want 0", i, snp[i]); end
            n_chk++; if (rv[i]  !== 1'b0) begin n_fail++; $display("FAIL reset_rv[%0d]: got %b want 0", i, rv[i]); end
            n_chk++; if (hv[i]  !== 1'b0) begin n_fail++; $display("FAIL reset_hit[%0d]: got %b want 0", i, hv[i]); end
            n_chk++; if (sc[i]  !== 8'd0) begin n_fail++; $display("FAIL reset_score[%0d]: got %0d want 0", i, sc[i]); end
            n_chk++; if (rl[i]  !== 4'd0) begin n_fail++; $display("FAIL reset_rounds[%0d]: got %0d want 0", i, rl[i]); end
            n_chk++; if (go[i]  !== 1'b0) begin n_fail++; $display("FAIL reset_go[%0d]: got %b want 0", i, go[i]); end
        end
        reset = 1'b0; ena = 1'b1; btn_start = 1'b0; shot_valid = 1'b0;
        nxt();
    endtask

    task automatic test_start_latency();
        target_x = 5'd10; target_y = 5'd30;
        btn_start = 1'b1;
        #1;
        n_chk++; if (snp[0] !== 1'b0) begin n_fail++; $display("FAIL snp_cycle0: got %b want 0", snp[0]); end
        nxt();
        btn_start = 1'b0;
        #1;
        n_chk++; if (snp[0] !== 1'b1) begin n_fail++; $display("FAIL snp_cycle1: got %b want 1", snp[0]); end
        n_chk++; if (snp[1] !== 1'b1) begin n_fail++; $display("FAIL snp_cycle1_b: got %b want 1", snp[1]); end
        n_chk++; if (rl[0] !== 4'd8) begin n_fail++; $display("FAIL start_rounds: got %0d want 8", rl[0]); end
        n_chk++; if (rl[1] !== 4'd2) begin n_fail++; $display("FAIL start_rounds_b: got %0d want 2", rl[1]); end
        n_chk++; if (sc[0] !== 8'd0) begin n_fail++; $display("FAIL start_score: got %0d want 0", sc[0]); end
        nxt();
        #1;
        n_chk++; if (snp[0] !== 1'b0) begin n_fail++; $display("FAIL snp_cycle2: got %b want 0", snp[0]); end
        nxt();
        shot_x = 5'd11; shot_y = 5'd30; shot_valid = 1'b1;
        #1;
        n_chk++; if (rv[0] !== 1'b0) begin n_fail++; $display("FAIL rv_cycle3: got %b want 0", rv[0]); end
        nxt();
        shot_valid = 1'b0;
        #1;
        n_chk++; if (rv[0] !== 1'b1) begin n_fail++; $display("FAIL rv_cycle4: got %b want 1", rv[0]); end
        n_chk++; if (hv[0] !== 1'b1) begin n_fail++; $display("FAIL hit_tol1: got %b want 1", hv[0]); end
        n_chk++; if (sc[0] !== 8'd1) begin n_fail++; $display("FAIL score_first: got %0d want 1", sc[0]); end
        n_chk++; if (rl[0] !== 4'd7) begin n_fail++; $display("FAIL rounds_first: got %0d want 7", rl[0]); end
        n_chk++; if (hv[1] !== 1'b0) begin n_fail++; $display("FAIL hit_tol0_b: got %b want 0", hv[1]); end
        n_chk++; if (rl[1] !== 4'd1) begin n_fail++; $display("FAIL rounds_first_b: got %0d want 1", rl[1]); end
        nxt();
        #1;
        n_chk++; if (rv[0] !== 1'b0) begin n_fail++; $display("FAIL rv_single: got %b want 0", rv[0]); end
        n_chk++; if (snp[0] !== 1'b1) begin n_fail++; $display("FAIL snp_next_round: got %b want 1", snp[0]); end
    endtask

    task automatic test_hit_rules();
        shoot(0, 12, 30, 10, 30);
        n_chk++; if (rv[0] !== 1'b1) begin n_fail++; $display("FAIL rv_dx2: got %b want 1", rv[0]); end
        n_chk++; if (hv[0] !== 1'b0) begin n_fail++; $display("FAIL hit_dx2: got %b want 0", hv[0]); end
        n_chk++; if (sc[0] !== 8'd1) begin n_fail++; $display("FAIL score_dx2: got %0d want 1", sc[0]); end
        n_chk++; if (rl[0] !== 4'd6) begin n_fail++; $display("FAIL rounds_dx2: got %0d want 6", rl[0]); end
        shoot(0, 10, 31, 10, 30);
        n_chk++; if (hv[0] !== 1'b0) begin n_fail++; $display("FAIL hit_dy1: got %b want 0", hv[0]); end
        n_chk++; if (rl[0] !== 4'd5) begin n_fail++; $display("FAIL rounds_dy1: got %0d want 5", rl[0]); end
        n_chk++; if (go[1] !== 1'b1) begin n_fail++; $display("FAIL go_b_done: got %b want 1", go[1]); end
        n_chk++; if (rv[1] !== 1'b0) begin n_fail++; $display("FAIL rv_b_done: got %b want 0", rv[1]); end
        n_chk++; if (rl[1] !== 4'd0) begin n_fail++; $display("FAIL rounds_b_done: got %0d want 0", rl[1]); end
        shoot(0, 9, 30, 10, 30);
        n_chk++; if (hv[0] !== 1'b1) begin n_fail++; $display("FAIL hit_dx_neg1: got %b want 1", hv[0]); end
        n_chk++; if (sc[0] !== 8'd2) begin n_fail++; $display("FAIL score_dx_neg1: got %0d want 2", sc[0]); end
        shoot(0, 31, 5, 0, 5);
        n_chk++; if (hv[0] !== 1'b0) begin n_fail++; $display("FAIL hit_nowrap: got %b want 0", hv[0]); end
        n_chk++; if (rl[0] !== 4'd3) begin n_fail++; $display("FAIL rounds_nowrap: got %0d want 3", rl[0]); end
        shoot(0, 1, 5, 0, 5);
        n_chk++; if (sc[0] !== 8'd3) begin n_fail++; $display("FAIL score_edge: got %0d want 3", sc[0]); end
    endtask

    task automatic test_timeout();
        reset = 1'b1; nxt(); reset = 1'b0;
        btn_start = 1'b1; nxt(); btn_start = 1'b0;
        wait_aim(1);
        for (int k = 0; k < 4; k++) begin
            #1;
            n_chk++; if (rv[1] !== 1'b0) begin n_fail++; $display("FAIL tmo_early[%0d]: got %b want 0", k, rv[1]); end
            nxt();
        end
        #1;
        n_chk++; if (rv[1] !== 1'b1) begin n_fail++; $display("FAIL tmo_rv: got %b want 1", rv[1]); end
        n_chk++; if (hv[1] !== 1'b0) begin n_fail++; $display("FAIL tmo_hit: got %b want 0", hv[1]); end
        n_chk++; if (rl[1] !== 4'd1) begin n_fail++; $display("FAIL tmo_rounds: got %0d want 1", rl[1]); end
        wait_aim(1);
        nxt(); nxt(); nxt();
        target_x = 5'd7; target_y = 5'd7; shot_x = 5'd7; shot_y = 5'd7; shot_valid = 1'b1;
        nxt();
        shot_valid = 1'b0;
        #1;
        n_chk++; if (rv[1] !== 1'b1) begin n_fail++; $display("FAIL tmo_shot_rv: got %b want 1", rv[1]); end
        n_chk++; if (hv[1] !== 1'b1) begin n_fail++; $display("FAIL tmo_shot_hit: got %b want 1", hv[1]); end
        n_chk++; if (sc[1] !== 8'd1) begin n_fail++; $display("FAIL tmo_shot_score: got %0d want 1", sc[1]); end
        nxt();
        #1;
        n_chk++; if (go[1] !== 1'b1) begin n_fail++; $display("FAIL tmo_done: got %b want 1", go[1]); end
    endtask

    task automatic test_game_over();
        reset = 1'b1; nxt(); reset = 1'b0;
        btn_start = 1'b1; nxt(); btn_start = 1'b0;
        shoot(1, 4, 4, 4, 4);
        n_chk++; if (sc[1] !== 8'd1) begin n_fail++; $display("FAIL go_score1: got %0d want 1", sc[1]); end
        shoot(1, 20, 3, 20, 3);
        n_chk++; if (rv[1] !== 1'b1) begin n_fail++; $display("FAIL go_rv2: got %b want 1", rv[1]); end
        n_chk++; if (sc[1] !== 8'd2) begin n_fail++; $display("FAIL go_score2: got %0d want 2", sc[1]); end
        n_chk++; if (rl[1] !== 4'd0) begin n_fail++; $display("FAIL go_rounds0: got %0d want 0", rl[1]); end
        nxt();
        for (int k = 0; k < 3; k++) begin
            shot_valid = 1'b1; shot_x = 5'($urandom_range(0, 31)); shot_y = 5'($urandom_range(0, 31));
            #1;
            n_chk++; if (go[1] !== 1'b1) begin n_fail++; $display("FAIL go_flag[%0d]: got %b want 1", k, go[1]); end
            n_chk++; if (sc[1] !== 8'd2) begin n_fail++; $display("FAIL go_hold_score[%0d]: got %0d want 2", k, sc[1]); end
            n_chk++; if (hv[1] !== 1'b1) begin n_fail++; $display("FAIL go_hold_hit[%0d]: got %b want 1", k, hv[1]); end
            nxt();
        end
        shot_valid = 1'b0;
        btn_start = 1'b1;
        #1;
        n_chk++; if (snp[1] !== 1'b0) begin n_fail++; $display("FAIL restart_snp_early: got %b want 0", snp[1]); end
        nxt();
        btn_start = 1'b0;
        #1;
        n_chk++; if (snp[1] !== 1'b1) begin n_fail++; $display("FAIL restart_snp: got %b want 1", snp[1]); end
        n_chk++; if (sc[1] !== 8'd0) begin n_fail++; $display("FAIL restart_score: got %0d want 0", sc[1]); end
        n_chk++; if (rl[1] !== 4'd2) begin n_fail++; $display("FAIL restart_rounds: got %0d want 2", rl[1]); end
        n_chk++; if (go[1] !== 1'b0) begin n_fail++; $display("FAIL restart_go: got %b want 0", go[1]); end
    endtask

    task automatic test_ena_pulses();
        reset = 1'b1; nxt(); reset = 1'b0;
        target_x = 5'd3; target_y = 5'd9; shot_x = 5'd3; shot_y = 5'd9;
        shot_valid = 1'b1; nxt(); shot_valid = 1'b0;
        #1;
        n_chk++; if (sc[0] !== 8'd0) begin n_fail++; $display("FAIL idle_shot_score: got %0d want 0", sc[0]); end
        n_chk++; if (rl[0] !== 4'd0) begin n_fail++; $display("FAIL idle_shot_rounds: got %0d want 0", rl[0]); end
        btn_start = 1'b1; nxt(); btn_start = 1'b0;
        ena = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_chk++; if (snp[0] !== 1'b0) begin n_fail++; $display("FAIL stall_snp[%0d]: got %b want 0", k, snp[0]); end
            nxt();
        end
        ena = 1'b1;
        #1;
        n_chk++; if (snp[0] !== 1'b1) begin n_fail++; $display("FAIL delayed_snp: got %b want 1", snp[0]); end
        nxt();
        #1;
        n_chk++; if (snp[0] !== 1'b0) begin n_fail++; $display("FAIL snp_once: got %b want 0", snp[0]); end
        shot_valid = 1'b1; nxt(); shot_valid = 1'b0;
        #1;
        n_chk++; if (rv[0] !== 1'b0) begin n_fail++; $display("FAIL settle_shot_rv: got %b want 0", rv[0]); end
        n_chk++; if (rl[0] !== 4'd8) begin n_fail++; $display("FAIL settle_shot_rounds: got %0d want 8", rl[0]); end
        shot_valid = 1'b1; nxt(); shot_valid = 1'b0;
        ena = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_chk++; if (rv[0] !== 1'b0) begin n_fail++; $display("FAIL stall_rv[%0d]: got %b want 0", k, rv[0]); end
            n_chk++; if (rl[0] !== 4'd7) begin n_fail++; $display("FAIL stall_rounds[%0d]: got %0d want 7", k, rl[0]); end
            nxt();
        end
        ena = 1'b1;
        #1;
        n_chk++; if (rv[0] !== 1'b1) begin n_fail++; $display("FAIL delayed_rv: got %b want 1", rv[0]); end
        nxt();
        #1;
        n_chk++; if (rv[0] !== 1'b0) begin n_fail++; $display("FAIL rv_once: got %b want 0", rv[0]); end
        n_chk++; if (snp[0] !== 1'b1) begin n_fail++; $display("FAIL post_stall_snp: got %b want 1", snp[0]); end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1; nxt(); reset = 1'b0;
        btn_start = 1'b1; nxt(); btn_start = 1'b0;
        wait_aim(0);
        target_x = 5'd15; target_y = 5'd15; shot_x = 5'd15; shot_y = 5'd15;
        reset = 1'b1; shot_valid = 1'b1;
        nxt();
        reset = 1'b0; shot_valid = 1'b0;
        #1;
        n_chk++; if (rv[0] !== 1'b0) begin n_fail++; $display("FAIL aim_rst_rv: got %b want 0", rv[0]); end
        n_chk++; if (sc[0] !== 8'd0) begin n_fail++; $display("FAIL aim_rst_score: got %0d want 0", sc[0]); end
        n_chk++; if (rl[0] !== 4'd0) begin n_fail++; $display("FAIL aim_rst_rounds: got %0d want 0", rl[0]); end
        n_chk++; if (hv[0] !== 1'b0) begin n_fail++; $display("FAIL aim_rst_hit: got %b want 0", hv[0]); end
        n_chk++; if (snp[0] !== 1'b0) begin n_fail++; $display("FAIL aim_rst_snp: got %b want 0", snp[0]); end
        n_chk++; if (go[0] !== 1'b0) begin n_fail++; $display("FAIL aim_rst_go: got %b want 0", go[0]); end
        nxt();
        #1;
        n_chk++; if (rv[0] !== 1'b0) begin n_fail++; $display("FAIL aim_rst_late_rv: got %b want 0", rv[0]); end
        btn_start = 1'b1; nxt(); btn_start = 1'b0;
        shoot(0, 15, 15, 15, 15);
        reset = 1'b1;
        #1;
        n_chk++; if (rv[0] !== 1'b0) begin n_fail++; $display("FAIL judge_rst_rv: got %b want 0", rv[0]); end
        nxt();
        reset = 1'b0;
        #1;
        n_chk++; if (sc[0] !== 8'd0) begin n_fail++; $display("FAIL judge_rst_score: got %0d want 0", sc[0]); end
        n_chk++; if (rl[0] !== 4'd0) begin n_fail++; $display("FAIL judge_rst_rounds: got %0d want 0", rl[0]); end
    endtask

    task automatic test_random();
        int d;
        int sx;
        reset = 1'b1; nxt();
        for (int c = 0; c < 4000; c++) begin
            reset      = ($urandom_range(0, 299) == 0);
            ena        = ($urandom_range(0, 4) != 0);
            btn_start  = ($urandom_range(0, 15) == 0);
            shot_valid = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) begin
                target_x = 5'($urandom_range(0, 31));
                target_y = 5'($urandom_range(0, 31));
            end
            d  = int'($urandom_range(0, 4)) - 2;
            sx = int'(target_x) + d;
            if (sx < 0) sx = 0;
            if (sx > 31) sx = 31;
            shot_x = 5'(sx);
            shot_y = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : target_y;
            #1;
            for (int i = 0; i < 2; i++) begin
                n_chk++; if (snp[i] !== exp_snp(i)) begin n_fail++; $display("FAIL rnd_snp c%0d i%0d: got %b want %b", c, i, snp[i], exp_snp(i)); end
                n_chk++; if (rv[i] !== exp_rv(i)) begin n_fail++; $display("FAIL rnd_rv c%0d i%0d: got %b want %b", c, i, rv[i], exp_rv(i)); end
                n_chk++; if (hv[i] !== m_hit[i]) begin n_fail++; $display("FAIL rnd_hit c%0d i%0d: got %b want %b", c, i, hv[i], m_hit[i]); end
                n_chk++; if (sc[i] !== 8'(m_score[i])) begin n_fail++; $display("FAIL rnd_score c%0d i%0d: got %0d want %0d", c, i, sc[i], m_score[i]); end
                n_chk++; if (rl[i] !== 4'(m_rnd[i])) begin n_fail++; $display("FAIL rnd_rounds c%0d i%0d: got %0d want %0d", c, i, rl[i], m_rnd[i]); end
                n_chk++; if (go[i] !== (m_ph[i] == P_DONE)) begin n_fail++; $display("FAIL rnd_go c%0d i%0d: got %b want %b", c, i, go[i], m_ph[i] == P_DONE); end
            end
            nxt();
        end
    endtask

    initial begin
        reset = 1'b1; ena = 1'b1; btn_start = 1'b0; shot_valid = 1'b0;
        shot_x = '0; shot_y = '0; target_x = '0; target_y = '0;
        for (int i = 0; i < 2; i++) begin
            m_ph[i] = P_IDLE; m_age[i] = 0; m_score[i] = 0; m_rnd[i] = 0; m_hit[i] = 1'b0;
        end
        test_reset();
        test_start_latency();
        test_hit_rules();
        test_timeout();
        test_game_over();
        test_ena_pulses();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/round_ctrl.md
ROUND_CTRL -- requirements
Module: round_ctrl

Interface
- REQ-001: Parameter NUM_ROUNDS, default 8, rounds per game (1..15).
- REQ-002: Parameter TIMEOUT_CYCLES, default 1000, enabled cycles allowed per aim window (1..65535).
- REQ-003: Parameter TOL_X, default 1, hit tolerance on X distance (0..31).
- REQ-004: clk  input  1  single clock; all state changes on its rising edge.
- REQ-005: reset  input  1  synchronous, active-high reset.
- REQ-006: ena  input  1  global enable; when low, all state and counters hold.
- REQ-007: btn_start  input  1  one-cycle request to begin a game.
- REQ-008: shot_valid  input  1  player shot strobe.
- REQ-009: shot_x, shot_y  input  5 each  shot coordinates, unsigned.
- REQ-010: target_x, target_y  input  5 each  current target from the target generator.
- REQ-011: start_new_game  output  1  one-cycle pulse requesting a new target.
- REQ-012: result_valid  output  1  one-cycle pulse marking a judged round.
- REQ-013: hit  output  1  result of the last judged round.
- REQ-014: score  output  8  hits this game.
- REQ-015: rounds_left  output  4  rounds remaining.
- REQ-016: game_over  output  1  high while in DONE.

Function
- REQ-017: FSM states are IDLE, LOAD, SETTLE, AIM, JUDGE and DONE; the FSM advances only in cycles with ena=1.
- REQ-018: IDLE or DONE with btn_start=1 SHALL go to LOAD, clear score to 0 and load rounds_left=NUM_ROUNDS.
- REQ-019: btn_start in any other state SHALL be ignored.
- REQ-020: LOAD SHALL drive start_new_game=1 for exactly that cycle, then go to SETTLE.
- REQ-021: SETTLE SHALL last one cycle, so that the target is stable before aiming, then go to AIM.
- REQ-022: Entering AIM SHALL clear the 16-bit timeout counter.
- REQ-023: Each enabled AIM cycle without a shot SHALL increment the timeout counter.
- REQ-024: In AIM, shot_valid=1 SHALL go to JUDGE, with the hit evaluated from shot and target values sampled in that cycle.
- REQ-025: In AIM with no shot and counter == TIMEOUT_CYCLES-1, the FSM SHALL go to JUDGE with hit=0.
- REQ-026: When a shot and timeout occur in the same cycle, the shot SHALL win.
- REQ-027: A shot is a hit when shot_y == target_y and |shot_x - target_x| <= TOL_X; the distance is computed in 6-bit unsigned form with no wrap-around (31 vs 0 is distance 31).
- REQ-028: hit, score and rounds_left SHALL update on the edge entering JUDGE, so they are valid together with result_valid.
- REQ-029: score SHALL increment on a hit and saturate at 255.
- REQ-030: rounds_left SHALL decrement by 1 per judged round and never wrap below 0.
- REQ-031: JUDGE SHALL drive result_valid=1 for one cycle, then go to DONE if rounds_left==0, else to LOAD.
- REQ-032: shot_valid outside AIM SHALL be ignored.
- REQ-033: In DONE, game_over=1; score and hit SHALL hold until the next btn_start.
- REQ-034: With ena=0, start_new_game and result_valid SHALL be 0 and all registers hold; a pulse state SHALL emit its pulse on the next enabled cycle.
- REQ-035: Latency: btn_start at enabled cycle N gives start_new_game at N+1 and AIM from N+3.
- REQ-036: A shot at cycle M in AIM gives result_valid at M+1.

Reset
- REQ-037: Reset SHALL take priority over ena and all inputs.
- REQ-038: On reset, the FSM enters IDLE and score=0, rounds_left=0, hit=0, start_new_game=0, result_valid=0, game_over=0, and the timeout counter is cleared.
- REQ-039: Reset asserted mid-game (any state) SHALL abort the game with no result_valid pulse.

Verification
- REQ-040: Reset then btn_start at cycle 0 (ena=1) -> start_new_game=1 at cycle 1 only, AIM from cycle 3, rounds_left=8, score=0.
- REQ-041: target (10,30), shot (11,30) with TOL_X=1 -> result_valid=1, hit=1, score=1, rounds_left=7; shot (12,30) -> hit=0, score unchanged; shot (10,31) -> hit=0.
- REQ-042: TIMEOUT_CYCLES=4 with no shot -> JUDGE entered after 4 AIM cycles, hit=0; a shot on the 4th AIM cycle -> judged as a shot.
- REQ-043: NUM_ROUNDS=2, two hits -> game_over=1, score=2, rounds_left=0; btn_start -> score=0, rounds_left=2, start_new_game pulses.
- REQ-044: ena toggled low for 3 cycles during LOAD and JUDGE -> each pulse is emitted exactly once, delayed by 3 cycles; shots during IDLE/SETTLE/DONE -> no change in score or rounds_left.
- REQ-045: Reset asserted in AIM -> IDLE next cycle, all outputs 0, no result_valid pulse.
